// File: rtl/ex_sat_flag_stage.sv
// Execute-stage back end: ADD/SUB saturation, Z/V/N flag register, EX/MEM result register.
// Optional EX_FLAG_BYPASS_EN makes flags show the next-state value during a flag-updating capture.
module ex_sat_flag_stage #(
    parameter int DW  = 16,
    parameter int RW  = 4,
    parameter int SCW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [1:0]    in_op,
    input  logic [DW-1:0] in_sum,
    input  logic          in_pos_ovfl,
    input  logic          in_neg_ovfl,
    input  logic [RW-1:0] in_dst,
    input  logic          in_wen,
    output logic          out_valid,
    output logic [DW-1:0] out_result,
    output logic [RW-1:0] out_dst,
    output logic          out_wen,
    output logic [2:0]    flags,
    output logic [SCW-1:0] sat_cnt
);

    localparam logic [1:0] OP_ADD    = 2'b00;
    localparam logic [1:0] OP_SUB    = 2'b01;
    localparam logic [1:0] OP_LOGIC  = 2'b10;
    localparam logic [1:0] OP_NOFLAG = 2'b11;

    localparam logic [DW-1:0]  SAT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0]  SAT_MIN = {1'b1, {(DW-1){1'b0}}};
    localparam logic [SCW-1:0] CNT_MAX = {SCW{1'b1}};

    logic          valid_q, valid_d;
    logic [DW-1:0] result_q, result_d;
    logic [RW-1:0] dst_q, dst_d;
    logic          wen_q, wen_d;
    logic [2:0]    flags_q, flags_d;
    logic [SCW-1:0] sat_cnt_q, sat_cnt_d;

    logic          cap;
    logic          is_arith;
    logic          ovfl;
    logic [DW-1:0] sat_res;
    logic [2:0]    flags_nxt;

    assign cap      = in_valid & ~stall & ~flush;
    assign is_arith = (in_op == OP_ADD) || (in_op == OP_SUB);
    assign ovfl     = in_pos_ovfl | in_neg_ovfl;

    // Positive overflow wins if the adder ever flags both.
    always_comb begin
        sat_res = in_sum;
        if (is_arith) begin
            if (in_pos_ovfl)      sat_res = SAT_MAX;
            else if (in_neg_ovfl) sat_res = SAT_MIN;
        end
    end

    always_comb begin
        flags_nxt = flags_q;
        case (in_op)
            OP_ADD, OP_SUB: flags_nxt = {(sat_res == '0), ovfl, sat_res[DW-1]};
            OP_LOGIC:       flags_nxt = {(in_sum == '0), flags_q[1:0]};
            OP_NOFLAG:      flags_nxt = flags_q;
            default:        flags_nxt = flags_q;
        endcase
    end

    always_comb begin
        valid_d   = valid_q;
        result_d  = result_q;
        dst_d     = dst_q;
        wen_d     = wen_q;
        flags_d   = flags_q;
        sat_cnt_d = sat_cnt_q;
        if (flush) begin
            valid_d = 1'b0;
            wen_d   = 1'b0;
        end else if (!stall) begin
            valid_d = in_valid;
            wen_d   = in_valid & in_wen;
            if (in_valid) begin
                result_d = sat_res;
                dst_d    = in_dst;
                flags_d  = flags_nxt;
                if (is_arith && ovfl && (sat_cnt_q != CNT_MAX))
                    sat_cnt_d = sat_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            result_q  <= '0;
            dst_q     <= '0;
            wen_q     <= 1'b0;
            flags_q   <= 3'b000;
            sat_cnt_q <= '0;
        end else begin
            valid_q   <= valid_d;
            result_q  <= result_d;
            dst_q     <= dst_d;
            wen_q     <= wen_d;
            flags_q   <= flags_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_result = result_q;
    assign out_dst    = dst_q;
    assign out_wen    = wen_q & valid_q;
    assign sat_cnt    = sat_cnt_q;

`ifdef EX_FLAG_BYPASS_EN
    // Branch in the next decode slot sees the flags being captured this cycle.
    assign flags = (cap && (in_op != OP_NOFLAG)) ? flags_nxt : flags_q;
`else
    assign flags = flags_q;
`endif

endmodule

// File: tb/tb_ex_sat_flag_stage.sv
// Directed, table-driven bench for ex_sat_flag_stage plus hand-written reset/bypass/counter sequences.
module tb_ex_sat_flag_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, in_valid;
    logic [1:0]  in_op;
    logic [15:0] in_sum;
    logic        in_pos_ovfl, in_neg_ovfl;
    logic [3:0]  in_dst;
    logic        in_wen;
    logic        out_valid;
    logic [15:0] out_result;
    logic [3:0]  out_dst;
    logic        out_wen;
    logic [2:0]  flags;
    logic [7:0]  sat_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ex_sat_flag_stage #(.DW(16), .RW(4), .SCW(8)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_op(in_op), .in_sum(in_sum),
        .in_pos_ovfl(in_pos_ovfl), .in_neg_ovfl(in_neg_ovfl),
        .in_dst(in_dst), .in_wen(in_wen),
        .out_valid(out_valid), .out_result(out_result), .out_dst(out_dst),
        .out_wen(out_wen), .flags(flags), .sat_cnt(sat_cnt)
    );

    typedef struct {
        logic        vld;
        logic [1:0]  op;
        logic [15:0] sum;
        logic        pos, neg;
        logic [3:0]  dst;
        logic        wen, stl, fls;
        logic        e_vld;
        logic [15:0] e_res;
        logic [3:0]  e_dst;
        logic        e_wen;
        logic [2:0]  e_flg;
        logic [7:0]  e_cnt;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(logic vld, logic [1:0] op, logic [15:0] sum, logic pos, logic neg,
                                logic [3:0] dst, logic wen, logic stl, logic fls,
                                logic e_vld, logic [15:0] e_res, logic [3:0] e_dst, logic e_wen,
                                logic [2:0] e_flg, logic [7:0] e_cnt);
        vec_t v;
        v.vld = vld; v.op = op; v.sum = sum; v.pos = pos; v.neg = neg;
        v.dst = dst; v.wen = wen; v.stl = stl; v.fls = fls;
        v.e_vld = e_vld; v.e_res = e_res; v.e_dst = e_dst; v.e_wen = e_wen;
        v.e_flg = e_flg; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        in_pos_ovfl = 1'b0; in_neg_ovfl = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        in_valid = v.vld; in_op = v.op; in_sum = v.sum;
        in_pos_ovfl = v.pos; in_neg_ovfl = v.neg;
        in_dst = v.dst; in_wen = v.wen; stall = v.stl; flush = v.fls;
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    task automatic chk_vec(input int i, input vec_t v);
        chk($sformatf("v%0d.valid", i),  {31'd0, out_valid}, {31'd0, v.e_vld});
        chk($sformatf("v%0d.result", i), {16'd0, out_result}, {16'd0, v.e_res});
        chk($sformatf("v%0d.dst", i),    {28'd0, out_dst}, {28'd0, v.e_dst});
        chk($sformatf("v%0d.wen", i),    {31'd0, out_wen}, {31'd0, v.e_wen});
        chk($sformatf("v%0d.flags", i),  {29'd0, flags}, {29'd0, v.e_flg});
        chk($sformatf("v%0d.sat_cnt", i), {24'd0, sat_cnt}, {24'd0, v.e_cnt});
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".valid"},  {31'd0, out_valid}, 32'd0);
        chk({tag, ".result"}, {16'd0, out_result}, 32'd0);
        chk({tag, ".dst"},    {28'd0, out_dst}, 32'd0);
        chk({tag, ".wen"},    {31'd0, out_wen}, 32'd0);
        chk({tag, ".flags"},  {29'd0, flags}, 32'd0);
        chk({tag, ".sat_cnt"}, {24'd0, sat_cnt}, 32'd0);
    endtask

    initial begin
        //          vld op     sum       pos  neg  dst   wen stl fls | vld res       dst   wen flg     cnt
        tbl[0]  = mk(1, 2'b00, 16'h0005, 0, 0, 4'd3,  1, 0, 0,   1, 16'h0005, 4'd3,  1, 3'b000, 8'd0);
        tbl[1]  = mk(1, 2'b00, 16'h0000, 0, 0, 4'd4,  1, 0, 0,   1, 16'h0000, 4'd4,  1, 3'b100, 8'd0);
        tbl[2]  = mk(1, 2'b00, 16'h8001, 1, 0, 4'd5,  1, 0, 0,   1, 16'h7FFF, 4'd5,  1, 3'b010, 8'd1);
        tbl[3]  = mk(1, 2'b01, 16'h7FFE, 0, 1, 4'd6,  1, 0, 0,   1, 16'h8000, 4'd6,  1, 3'b011, 8'd2);
        tbl[4]  = mk(1, 2'b10, 16'h0000, 1, 0, 4'd7,  1, 0, 0,   1, 16'h0000, 4'd7,  1, 3'b111, 8'd2);
        tbl[5]  = mk(1, 2'b11, 16'h1234, 0, 1, 4'd8,  0, 0, 0,   1, 16'h1234, 4'd8,  0, 3'b111, 8'd2);
        tbl[6]  = mk(1, 2'b00, 16'h00F0, 0, 0, 4'd2,  1, 1, 0,   1, 16'h1234, 4'd8,  0, 3'b111, 8'd2);
        tbl[7]  = mk(1, 2'b00, 16'h00F0, 0, 0, 4'd2,  1, 1, 0,   1, 16'h1234, 4'd8,  0, 3'b111, 8'd2);
        tbl[8]  = mk(1, 2'b00, 16'h00F0, 1, 0, 4'd2,  1, 1, 0,   1, 16'h1234, 4'd8,  0, 3'b111, 8'd2);
        tbl[9]  = mk(1, 2'b00, 16'h0000, 1, 0, 4'd2,  1, 1, 1,   0, 16'h1234, 4'd8,  0, 3'b111, 8'd2);
        tbl[10] = mk(0, 2'b00, 16'h0000, 0, 0, 4'd1,  1, 0, 0,   0, 16'h1234, 4'd8,  0, 3'b111, 8'd2);
        tbl[11] = mk(1, 2'b10, 16'h0100, 0, 0, 4'd9,  1, 0, 0,   1, 16'h0100, 4'd9,  1, 3'b011, 8'd2);
        tbl[12] = mk(1, 2'b00, 16'h8000, 0, 0, 4'd10, 1, 0, 0,   1, 16'h8000, 4'd10, 1, 3'b001, 8'd2);
        tbl[13] = mk(1, 2'b00, 16'h0000, 1, 0, 4'd11, 1, 0, 1,   0, 16'h8000, 4'd10, 0, 3'b001, 8'd2);
        tbl[14] = mk(1, 2'b01, 16'h0000, 1, 1, 4'd12, 1, 0, 0,   1, 16'h7FFF, 4'd12, 1, 3'b010, 8'd3);
        tbl[15] = mk(1, 2'b11, 16'hFFFF, 1, 0, 4'd13, 1, 0, 0,   1, 16'hFFFF, 4'd13, 1, 3'b010, 8'd3);

        rst_n = 1'b0;
        in_op = 2'b00; in_sum = '0; in_dst = '0; in_wen = 1'b0;
        idle();
        #12;
        chk_reset("por");
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            apply(tbl[i]);
            chk_vec(i, tbl[i]);
        end

        // Flag-updating capture: bypass build shows new flags before the edge.
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'b00; in_sum = 16'h0000; in_dst = 4'd14; in_wen = 1'b1;
        #1;
`ifdef EX_FLAG_BYPASS_EN
        chk("bypass.pre_edge", {29'd0, flags}, {29'd0, 3'b100});
`else
        chk("bypass.pre_edge", {29'd0, flags}, {29'd0, 3'b010});
`endif
        @(posedge clk);
        #1;
        idle();
        #1;
        chk("bypass.post_edge", {29'd0, flags}, {29'd0, 3'b100});
        chk("bypass.valid", {31'd0, out_valid}, 32'd1);

        // Asynchronous reset mid-stream, checked before any clock edge.
        rst_n = 1'b0;
        #1;
        chk_reset("async");
        @(negedge clk);
        rst_n = 1'b1;

        // Counter saturates at 0xFF and never wraps.
        for (int i = 0; i < 300; i++) begin
            apply(mk(1, 2'b00, 16'h8001, 1, 0, 4'd5, 1, 0, 0,
                     1, 16'h7FFF, 4'd5, 1, 3'b010, 8'd0));
            if (i == 253) chk("cnt.254", {24'd0, sat_cnt}, 32'd254);
            if (i == 254) chk("cnt.255", {24'd0, sat_cnt}, 32'd255);
        end
        chk("cnt.stick", {24'd0, sat_cnt}, 32'd255);
        chk("cnt.result", {16'd0, out_result}, 32'h7FFF);
        chk("cnt.flags", {29'd0, flags}, {29'd0, 3'b010});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_sat_flag_stage.md
Name: ex_sat_flag_stage

Overview:
- Execute-stage back end directly downstream of the 16-bit carry-lookahead adder.
- Consumes the adder's raw sum and positive/negative overflow indicators, and applies saturation for ADD/SUB.
- Computes and holds the Z/V/N flag register.
- Registers the result into the EX/MEM boundary with stall and flush control.
- Feeds the memory stage (result, destination, write enable) and the branch unit (flags).

Parameters:
- DW, 16, datapath width; saturation constants derive from it (max positive 0x7FFF, max negative 0x8000 at 16).
- RW, 4, register-specifier width.
- SCW, 8, width of the saturation-event counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active low.
- stall  input  1  hold all state this cycle.
- flush  input  1  squash the instruction being captured this cycle.
- in_valid  input  1  upstream instruction valid.
- in_op  input  2  op class: 00 ADD, 01 SUB, 10 LOGIC, 11 NOFLAG.
- in_sum  input  DW  adder sum, or the already-computed logic/shift result.
- in_pos_ovfl  input  1  positive overflow from the adder.
- in_neg_ovfl  input  1  negative overflow from the adder.
- in_dst  input  RW  destination register.
- in_wen  input  1  register write enable.
- out_valid  output  1  registered instruction valid.
- out_result  output  DW  registered (saturated) result.
- out_dst  output  RW  registered destination.
- out_wen  output  1  registered write enable, qualified by out_valid.
- flags  output  3  {Z,V,N} to the branch unit.
- sat_cnt  output  SCW  count of saturation events.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_result=0, out_dst=0, out_wen=0, flags=3'b000, sat_cnt=0.
- Reset mid-operation discards the in-flight instruction; there is no recovery of pre-reset state.
- Saturation applies to ADD/SUB only:
  - in_pos_ovfl=1 gives result 0x7FFF.
  - else in_neg_ovfl=1 gives result 0x8000.
  - else result = in_sum.
  - Both overflow bits high is illegal; pos_ovfl wins.
- LOGIC and NOFLAG pass in_sum unchanged. Overflow inputs are ignored for these classes.
- Capture condition: cap = in_valid & ~stall & ~flush.
- Latency: 1 cycle. Result, dst and wen appear on the edge after cap.
- Precedence: flush > stall > normal.
  - flush=1: next edge sets out_valid=0 and out_wen=0; flags and sat_cnt do not update; out_result/out_dst hold.
  - stall=1 (no flush): every register holds, including flags and sat_cnt.
  - No stall, no flush, in_valid=0 (bubble): out_valid=0, out_wen=0; out_result/out_dst hold their previous values.
- Flag update on a cap edge:
  - ADD/SUB: Z = (saturated result == 0); V = pos_ovfl | neg_ovfl; N = saturated result[DW-1].
  - LOGIC: Z = (in_sum == 0); V and N hold.
  - NOFLAG: all flags hold.
- N is taken from the saturated value. Positive overflow therefore gives N=0 and negative overflow gives N=1.
- sat_cnt increments on each cap with class ADD/SUB and either overflow bit set. It sticks at all-ones (0xFF) and never wraps. It is cleared only by reset.
- out_wen = registered in_wen & out_valid. It is never high on a bubble or a flush.

Optional Feature:
- Macro: EX_FLAG_BYPASS_EN.
- Defined: flags is combinational. While cap=1 and in_op is ADD/SUB/LOGIC, flags shows the next-state flag value in the same cycle, so a branch in the immediately following decode slot needs no stall. Otherwise flags equals the register.
- Undefined: flags is the flag register only; new flags are visible one cycle after the capture edge.
- Register contents, and the flags value in every cycle with no flag-updating capture, are identical in both builds.

Test Plan:
- Reset check: assert rst_n=0 mid-stream with out_valid=1 -> all outputs 0 immediately, without waiting for a clock edge; flags=000.
- ADD, no overflow: in_op=00, in_sum=0x0005 -> next cycle out_result=0x0005, out_valid=1, flags=000. Then ADD with in_sum=0x0000 -> flags=100.
- Overflow saturation:
  - ADD, in_pos_ovfl=1, in_sum=0x8001 -> out_result=0x7FFF, flags=010, sat_cnt=1.
  - SUB, in_neg_ovfl=1 -> out_result=0x8000, flags=011, sat_cnt=2.
- Stall/flush precedence: capture with stall=1 for 3 cycles -> outputs and flags frozen. Then stall=1 and flush=1 together -> out_valid=0, flags unchanged.
- LOGIC/NOFLAG: with flags=011, LOGIC in_sum=0 -> flags=111; NOFLAG in_sum=0x1234 -> flags stays 111, out_result=0x1234.
- Counter stick: 300 consecutive overflowing ADDs -> sat_cnt=0xFF and holds there. With EX_FLAG_BYPASS_EN defined, flags changes in the same cycle as cap.
